// File: rtl/simple_err_bcast.sv
// Error-frame broadcast buffer: captures LEN-word error frames into two banks
// and replays each stored frame REPEAT times on the output stream.
module simple_err_bcast #(
    parameter int LEN    = 4,
    parameter int REPEAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] stage_0_error,
    input  logic        stage_0_error_fst,
    input  logic        stage_0_error_vld,
    output logic        stage_0_error_rdy,
    output logic [31:0] stage_0_error_bc,
    output logic        stage_0_error_bc_fst,
    output logic        stage_0_error_bc_vld,
    input  logic        stage_0_error_bc_rdy,
    output logic        frame_err
);

    localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int CW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(LEN - 1);
    localparam logic [CW-1:0] C_LAST = CW'(REPEAT - 1);

    logic [31:0]   bank [2][LEN];
    logic [1:0]    full_q, full_d;
    logic          wb_q, wb_d;
    logic          rb_q, rb_d;
    logic [IW-1:0] wi_q, wi_d;
    logic [IW-1:0] ri_q, ri_d;
    logic [CW-1:0] rc_q, rc_d;
    logic          open_q, open_d;
    logic          err_q, err_d;

    logic          in_xfer, out_xfer;
    logic          in_fst, in_cont, in_drop;
    logic          wr_en;
    logic [IW-1:0] wr_idx;

    assign stage_0_error_rdy    = !full_q[wb_q];
    assign stage_0_error_bc_vld = full_q[rb_q];
    assign stage_0_error_bc     = bank[rb_q][ri_q];
    assign stage_0_error_bc_fst = (ri_q == '0);
    assign frame_err            = err_q;

    assign in_xfer  = stage_0_error_vld & stage_0_error_rdy;
    assign out_xfer = stage_0_error_bc_vld & stage_0_error_bc_rdy;
    assign in_fst   = in_xfer & stage_0_error_fst;
    assign in_cont  = in_xfer & !stage_0_error_fst & open_q;
    assign in_drop  = in_xfer & !stage_0_error_fst & !open_q;

    always_comb begin
        full_d = full_q;
        wb_d   = wb_q;
        rb_d   = rb_q;
        wi_d   = wi_q;
        ri_d   = ri_q;
        rc_d   = rc_q;
        open_d = open_q;
        err_d  = 1'b0;
        wr_en  = 1'b0;
        wr_idx = wi_q;

        // A new fst restarts the frame; an open partial frame is discarded
        unique case (1'b1)
            in_fst: begin
                wr_en  = 1'b1;
                wr_idx = '0;
                wi_d   = IW'(1);
                open_d = 1'b1;
                err_d  = open_q;
            end
            in_cont: begin
                wr_en  = 1'b1;
                wr_idx = wi_q;
                if (wi_q == I_LAST) begin
                    full_d[wb_q] = 1'b1;
                    wb_d         = ~wb_q;
                    wi_d         = '0;
                    open_d       = 1'b0;
                end else begin
                    wi_d = wi_q + IW'(1);
                end
            end
            in_drop: begin
                err_d = 1'b1;
            end
            default: ;
        endcase

        // Fill and release never target the same bank in one cycle
        if (out_xfer) begin
            if (ri_q == I_LAST) begin
                ri_d = '0;
                if (rc_q == C_LAST) begin
                    rc_d         = '0;
                    full_d[rb_q] = 1'b0;
                    rb_d         = ~rb_q;
                end else begin
                    rc_d = rc_q + CW'(1);
                end
            end else begin
                ri_d = ri_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= '0;
            wb_q   <= 1'b0;
            rb_q   <= 1'b0;
            wi_q   <= '0;
            ri_q   <= '0;
            rc_q   <= '0;
            open_q <= 1'b0;
            err_q  <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < LEN; i++) begin
                    bank[b][i] <= '0;
                end
            end
        end else begin
            full_q <= full_d;
            wb_q   <= wb_d;
            rb_q   <= rb_d;
            wi_q   <= wi_d;
            ri_q   <= ri_d;
            rc_q   <= rc_d;
            open_q <= open_d;
            err_q  <= err_d;
            if (wr_en) begin
                bank[wb_q][wr_idx] <= stage_0_error;
            end
        end
    end

endmodule

// File: tb/tb_simple_err_bcast.sv
// Directed bench for simple_err_bcast (LEN=4, REPEAT=3): capture, replay,
// double banking, backpressure, framing errors and reset.
module tb_simple_err_bcast;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] stage_0_error;
    logic        stage_0_error_fst;
    logic        stage_0_error_vld;
    logic        stage_0_error_rdy;
    logic [31:0] stage_0_error_bc;
    logic        stage_0_error_bc_fst;
    logic        stage_0_error_bc_vld;
    logic        stage_0_error_bc_rdy;
    logic        frame_err;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [32:0] got[$];
    int          got_cyc[$];
    int          in_cyc[$];
    int          err_cnt;
    int          stall_bad;
    int          stall_cnt;
    bit          prev_stall;
    logic [32:0] prev_out;
    bit          rand_mode;

    simple_err_bcast #(.LEN(4), .REPEAT(3)) dut (
        .clk                  (clk),
        .reset                (reset),
        .stage_0_error        (stage_0_error),
        .stage_0_error_fst    (stage_0_error_fst),
        .stage_0_error_vld    (stage_0_error_vld),
        .stage_0_error_rdy    (stage_0_error_rdy),
        .stage_0_error_bc     (stage_0_error_bc),
        .stage_0_error_bc_fst (stage_0_error_bc_fst),
        .stage_0_error_bc_vld (stage_0_error_bc_vld),
        .stage_0_error_bc_rdy (stage_0_error_bc_rdy),
        .frame_err            (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Inputs change at posedge+1, so the negedge view is what the next edge sees
    always @(negedge clk) begin
        if (stage_0_error_bc_vld && stage_0_error_bc_rdy) begin
            got.push_back({stage_0_error_bc_fst, stage_0_error_bc});
            got_cyc.push_back(cyc);
        end
        if (stage_0_error_vld && stage_0_error_rdy) in_cyc.push_back(cyc);
        if (frame_err) err_cnt++;
        if (prev_stall && (!stage_0_error_bc_vld ||
            {stage_0_error_bc_fst, stage_0_error_bc} !== prev_out))
            stall_bad++;
        prev_stall = stage_0_error_bc_vld && !stage_0_error_bc_rdy;
        prev_out   = {stage_0_error_bc_fst, stage_0_error_bc};
        if (prev_stall) stall_cnt++;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) stage_0_error_bc_rdy = 1'($urandom % 2);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset             = 1'b1;
        stage_0_error_vld = 1'b0;
        stage_0_error_fst = 1'b0;
        stage_0_error     = '0;
        step();
        step();
        reset      = 1'b0;
        got.delete();
        got_cyc.delete();
        in_cyc.delete();
        err_cnt    = 0;
        stall_bad  = 0;
        stall_cnt  = 0;
        prev_stall = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input logic f);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        stage_0_error_vld = 1'b1;
        stage_0_error     = d;
        stage_0_error_fst = f;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = stage_0_error_rdy;
            @(posedge clk);
            #1;
            n++;
        end
        stage_0_error_vld = 1'b0;
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL push_timeout data %h never accepted", d);
        end
    endtask

    task automatic push_frame(input logic [31:0] base);
        push(base, 1'b1);
        for (int i = 1; i < 4; i++) push(base + 32'(i), 1'b0);
    endtask

    task automatic wait_outputs(input int n);
        int k;
        k = 0;
        while (got.size() < n && k < 500) begin
            step();
            k++;
        end
        vectors++;
        if (got.size() < n) begin
            miscompares++;
            $display("FAIL wait_outputs got %0d outputs want %0d", got.size(), n);
        end
    endtask

    task automatic test_reset();
        rand_mode            = 1'b0;
        stage_0_error_bc_rdy = 1'b1;
        reset                = 1'b1;
        stage_0_error_vld    = 1'b0;
        stage_0_error_fst    = 1'b0;
        stage_0_error        = '0;
        step();
        vectors += 5;
        if (stage_0_error_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_rdy got %b want 1", stage_0_error_rdy);
        end
        if (stage_0_error_bc_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_vld got %b want 0", stage_0_error_bc_vld);
        end
        if (stage_0_error_bc_fst !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_fst got %b want 1", stage_0_error_bc_fst);
        end
        if (stage_0_error_bc !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data got %h want 0", stage_0_error_bc);
        end
        if (frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ferr got %b want 0", frame_err);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic [31:0] v [4];
        logic [32:0] exp;
        v = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        do_reset();
        stage_0_error_bc_rdy = 1'b1;
        push(v[0], 1'b1);
        push(v[1], 1'b0);
        push(v[2], 1'b0);
        vectors++;
        if (stage_0_error_bc_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL single_early_vld got %b want 0", stage_0_error_bc_vld);
        end
        push(v[3], 1'b0);
        vectors++;
        if (stage_0_error_bc_vld !== 1'b1 || stage_0_error_bc !== v[0] ||
            stage_0_error_bc_fst !== 1'b1) begin
            miscompares++;
            $display("FAIL single_latency got vld=%b fst=%b data=%h want 1 1 %h",
                     stage_0_error_bc_vld, stage_0_error_bc_fst, stage_0_error_bc, v[0]);
        end
        wait_outputs(12);
        repeat (3) step();
        vectors++;
        if (got.size() != 12 || stage_0_error_bc_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL single_count got %0d outputs vld=%b want 12 vld=0",
                     got.size(), stage_0_error_bc_vld);
        end
        for (int i = 0; i < 12 && i < got.size(); i++) begin
            exp = {(i % 4 == 0), v[i % 4]};
            vectors++;
            if (got[i] !== exp) begin
                miscompares++;
                $display("FAIL single_out[%0d] got %h want %h", i, got[i], exp);
            end
        end
        vectors++;
        if (got_cyc.size() < 12 || in_cyc.size() < 4 ||
            got_cyc[0] != in_cyc[3] + 1 || got_cyc[11] - got_cyc[0] != 11) begin
            miscompares++;
            $display("FAIL single_timing got first/last out cycle mismatch vs input want +1/+11");
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] base [3];
        logic [32:0] exp;
        int          k, r, i;
        base = '{32'hA0000000, 32'hB0000000, 32'hC0000000};
        do_reset();
        stage_0_error_bc_rdy = 1'b1;
        for (int f = 0; f < 3; f++) push_frame(base[f]);
        wait_outputs(36);
        repeat (3) step();
        vectors++;
        if (got.size() != 36 || in_cyc.size() != 12) begin
            miscompares++;
            $display("FAIL b2b_count got out=%0d in=%0d want 36 12", got.size(), in_cyc.size());
        end else begin
            for (int j = 0; j < 36; j++) begin
                k   = j / 12;
                r   = j % 12;
                i   = r % 4;
                exp = {(i == 0), base[k] + 32'(i)};
                vectors++;
                if (got[j] !== exp) begin
                    miscompares++;
                    $display("FAIL b2b_out[%0d] got %h want %h", j, got[j], exp);
                end
            end
            vectors += 3;
            if (in_cyc[4] != in_cyc[3] + 1) begin
                miscompares++;
                $display("FAIL b2b_b_capture got cycle %0d want %0d", in_cyc[4], in_cyc[3] + 1);
            end
            if (in_cyc[8] != got_cyc[11] + 1) begin
                miscompares++;
                $display("FAIL b2b_c_stall got cycle %0d want %0d", in_cyc[8], got_cyc[11] + 1);
            end
            if (got_cyc[35] - got_cyc[0] != 35) begin
                miscompares++;
                $display("FAIL b2b_gaps got span %0d want 35", got_cyc[35] - got_cyc[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] base [2];
        logic [32:0] exp;
        int          i;
        base = '{32'h3F800000, 32'hD0000000};
        do_reset();
        rand_mode = 1'b1;
        push_frame(base[0]);
        push_frame(base[1]);
        wait_outputs(24);
        rand_mode            = 1'b0;
        stage_0_error_bc_rdy = 1'b1;
        repeat (3) step();
        for (int j = 0; j < 24 && j < got.size(); j++) begin
            i   = j % 4;
            exp = {(i == 0), base[j / 12] + 32'(i)};
            vectors++;
            if (got[j] !== exp) begin
                miscompares++;
                $display("FAIL bp_out[%0d] got %h want %h", j, got[j], exp);
            end
        end
        vectors += 2;
        if (stall_bad != 0) begin
            miscompares++;
            $display("FAIL bp_hold got %0d changes while stalled want 0", stall_bad);
        end
        if (stall_cnt == 0) begin
            miscompares++;
            $display("FAIL bp_stalls got 0 stalled cycles want >0");
        end
    endtask

    task automatic test_framing();
        logic [31:0] v [4];
        logic [32:0] exp;
        v = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        do_reset();
        stage_0_error_bc_rdy = 1'b1;
        push(32'h11111111, 1'b1);
        push(32'h22222222, 1'b0);
        vectors++;
        if (frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL frm_no_err got %b want 0", frame_err);
        end
        push(v[0], 1'b1);
        vectors++;
        if (frame_err !== 1'b1) begin
            miscompares++;
            $display("FAIL frm_restart_err got %b want 1", frame_err);
        end
        for (int i = 1; i < 4; i++) push(v[i], 1'b0);
        wait_outputs(12);
        repeat (3) step();
        vectors++;
        if (err_cnt != 1 || got.size() != 12) begin
            miscompares++;
            $display("FAIL frm_count got err=%0d out=%0d want 1 12", err_cnt, got.size());
        end
        for (int i = 0; i < 12 && i < got.size(); i++) begin
            exp = {(i % 4 == 0), v[i % 4]};
            vectors++;
            if (got[i] !== exp) begin
                miscompares++;
                $display("FAIL frm_out[%0d] got %h want %h", i, got[i], exp);
            end
        end
        push(32'h33333333, 1'b0);
        vectors++;
        if (frame_err !== 1'b1) begin
            miscompares++;
            $display("FAIL frm_stray_err got %b want 1", frame_err);
        end
        step();
        vectors++;
        if (frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL frm_pulse_width got %b want 0", frame_err);
        end
        repeat (10) step();
        vectors++;
        if (got.size() != 12 || stage_0_error_bc_vld !== 1'b0 || err_cnt != 2) begin
            miscompares++;
            $display("FAIL frm_stray_drop got out=%0d vld=%b err=%0d want 12 0 2",
                     got.size(), stage_0_error_bc_vld, err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [32:0] exp;
        do_reset();
        stage_0_error_bc_rdy = 1'b0;
        push_frame(32'hA0000000);
        push_frame(32'hB0000000);
        vectors++;
        if (stage_0_error_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_full_rdy got %b want 0", stage_0_error_rdy);
        end
        stage_0_error_bc_rdy = 1'b1;
        repeat (5) step();
        stage_0_error_bc_rdy = 1'b0;
        reset                = 1'b1;
        vectors++;
        if (got.size() != 5) begin
            miscompares++;
            $display("FAIL mid_pre_count got %0d want 5", got.size());
        end
        step();
        vectors++;
        if (stage_0_error_bc_vld !== 1'b0 || stage_0_error_rdy !== 1'b1 ||
            stage_0_error_bc !== 32'h0 || stage_0_error_bc_fst !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset got vld=%b rdy=%b data=%h fst=%b want 0 1 0 1",
                     stage_0_error_bc_vld, stage_0_error_rdy,
                     stage_0_error_bc, stage_0_error_bc_fst);
        end
        reset = 1'b0;
        got.delete();
        stage_0_error_bc_rdy = 1'b1;
        push_frame(32'hE0000000);
        wait_outputs(12);
        repeat (5) step();
        vectors++;
        if (got.size() != 12) begin
            miscompares++;
            $display("FAIL mid_post_count got %0d want 12", got.size());
        end
        for (int i = 0; i < 12 && i < got.size(); i++) begin
            exp = {(i % 4 == 0), 32'hE0000000 + 32'(i % 4)};
            vectors++;
            if (got[i] !== exp) begin
                miscompares++;
                $display("FAIL mid_out[%0d] got %h want %h", i, got[i], exp);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_framing();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/simple_err_bcast.md
# simple_err_bcast

Error-frame broadcast buffer directly downstream of the simple error stage: captures each frame of error values produced on the `stage_0_error` stream and replays the whole frame `REPEAT` times on an output stream, once per consumer row of the backward (weight-update) pass. Double-banked: one frame can be captured while the previous frame is being replayed. Error values are opaque `float_24_8` words (32 bits); no arithmetic is performed on them.

## Interface
- `LEN`, 4: error elements per frame (≥2).
- `REPEAT`, 3: replays of each stored frame (≥1).

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `stage_0_error`  in  float_24_8 (32)  incoming error value.
- `stage_0_error_fst`  in  1  marks first element of a frame.
- `stage_0_error_vld`  in  1  input valid.
- `stage_0_error_rdy`  out  1  input ready.
- `stage_0_error_bc`  out  float_24_8 (32)  replayed error value.
- `stage_0_error_bc_fst`  out  1  first element of each replay.
- `stage_0_error_bc_vld`  out  1  output valid.
- `stage_0_error_bc_rdy`  in  1  output ready from consumer.
- `frame_err`  out  1  one-cycle pulse on a framing violation.

## Operation
- Transfer on either stream occurs when `vld & rdy` are high at a rising edge.
- Storage: two banks of `LEN` × 32-bit registers; per-bank `full` flag; write bank pointer `wb`, write index `wi` (0..LEN-1), `open` flag (frame in progress); read bank pointer `rb`, read index `ri`, repeat counter `rc` (0..REPEAT-1).
- Input: `stage_0_error_rdy = !full[wb]` (registered state only; no combinational path from `stage_0_error_bc_rdy`).
- Accepted word with `fst=1`: written at index 0, `wi←1`, `open←1`. If `open` was already 1, the partial frame is discarded (overwritten) and `frame_err` pulses.
- Accepted word with `fst=0`, `open=1`: written at `wi`, `wi←wi+1`.
- Accepted word with `fst=0`, `open=0`: dropped, no state change except `frame_err` pulse.
- Accepting the word at index `LEN-1`: `full[wb]←1`, `wb` toggles, `wi←0`, `open←0`. A `fst=1` word arriving when `LEN==1` is not supported (LEN≥2).
- Output: `stage_0_error_bc_vld = full[rb]`; `stage_0_error_bc = bank[rb][ri]`; `stage_0_error_bc_fst = (ri==0)`.
- On output transfer: `ri` increments; at `ri==LEN-1`, `ri←0` and `rc` increments; at `ri==LEN-1 & rc==REPEAT-1`, `rc←0`, `full[rb]←0`, `rb` toggles.
- Simultaneous fill of one bank and release of the other in the same cycle: both take effect; no conflict since banks differ.
- Reset (synchronous, any time, including mid-frame or mid-replay): all bank registers 0, `full=00`, `wb=rb=0`, `wi=ri=rc=0`, `open=0`; partial and stored frames are lost.

## Timing
- Reset values (cycle after `reset` sampled high, and while held): `stage_0_error_rdy=1`, `stage_0_error_bc_vld=0`, `stage_0_error_bc_fst=1`, `stage_0_error_bc=0`, `frame_err=0`.
- Latency: last element of a frame accepted at edge t → `stage_0_error_bc_vld=1` with element 0 in the cycle following t.
- Throughput: 1 word/cycle on each side; replay of one frame takes `LEN×REPEAT` output transfers.
- Input stalls (`rdy=0`) only when both banks are full; it re-asserts the cycle after the final output transfer of the bank under `wb`.
- `frame_err` is registered: high exactly the cycle after the offending transfer.
- Output data/fst are stable while `vld=1 & rdy=0`.

## Test plan
- Single frame, LEN=4, REPEAT=3, values 0x3F800000..0x40800000 (1.0,2.0,3.0,4.0), output rdy=1 -> 12 outputs 1,2,3,4 ×3, fst on outputs 0,4,8; vld rises the cycle after the 4th input.
- Back-to-back frames A,B,C with output rdy=1 -> A captured, B captured during A replay, C stalled (`stage_0_error_rdy=0`) until A's 12th transfer; output order A×3, B×3, C×3 with no gaps.
- Output backpressure: random `stage_0_error_bc_rdy` (50%) -> sequence identical to rdy=1 case; held data unchanged while stalled.
- Framing: send 2 words (fst,−), then fst frame of 4 -> one `frame_err` pulse; replay contains only the 4-word frame. Send a fst=0 word while idle -> dropped, `frame_err` pulse, no output.
- Reset mid-replay (after 5 outputs) with second bank full -> next cycle `vld=0`, `rdy=1`; new frame afterward replays correctly from bank 0.
